pipelined_wallace_multiplier: RTL

PIPELINED_WALLACE_MULTIPLIER -- requirements
Module: pipelined_wallace_multiplier

---
 rtl/pipelined_wallace_multiplier_if.sv | 25 ++
 rtl/pipelined_wallace_multiplier.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pipelined_wallace_multiplier_if.sv
// Operand/result handshake bundle for the pipelined Wallace multiplier.
// The producer/consumer side uses master; the multiplier uses slave.
interface pipelined_wallace_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_signed;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   Product;
    logic                 busy;

    modport master (
        output in_valid, in_signed, A, B, out_ready,
        input  in_ready, out_valid, Product, busy
    );

    modport slave (
        input  in_valid, in_signed, A, B, out_ready,
        output in_ready, out_valid, Product, busy
    );
endinterface

// File: rtl/pipelined_wallace_multiplier.sv
// Three-stage multiplier: operand capture, Baugh-Wooley partial products with
// carry-save (4:2 / full / half adder) row reduction, then a carry-propagate add.
module pipelined_wallace_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    pipelined_wallace_multiplier_if.slave   bus
);
    localparam int PW = 2 * WIDTH;

    typedef logic [PW-1:0] row_t;

    // Signed-mode correction constant: bits WIDTH and 2*WIDTH-1 of modified Baugh-Wooley.
    localparam row_t BW_CONST = (row_t'(1'b1) << WIDTH) | (row_t'(1'b1) << (PW - 1));

    function automatic row_t fa_sum(input row_t a, input row_t b, input row_t c);
        return a ^ b ^ c;
    endfunction

    function automatic row_t fa_carry(input row_t a, input row_t b, input row_t c);
        row_t maj;
        maj = (a & b) | (a & c) | (b & c);
        return {maj[PW-2:0], 1'b0};
    endfunction

    function automatic row_t ha_sum(input row_t a, input row_t b);
        return a ^ b;
    endfunction

    function automatic row_t ha_carry(input row_t a, input row_t b);
        row_t both;
        both = a & b;
        return {both[PW-2:0], 1'b0};
    endfunction

    logic              en_s;
    logic [WIDTH-1:0]  s1_a_r;
    logic [WIDTH-1:0]  s1_b_r;
    logic              s1_sgn_r;
    logic              s1_vld_r;
    row_t              s2_sum_r;
    row_t              s2_carry_r;
    logic              s2_sgn_r;
    logic              s2_vld_r;
    row_t              prod_r;
    logic              s3_vld_r;
    row_t              pp_s [WIDTH];
    row_t              red_sum_s;
    row_t              red_carry_s;

    assign en_s          = !s3_vld_r || bus.out_ready;
    assign bus.in_ready  = en_s;
    assign bus.out_valid = s3_vld_r;
    assign bus.Product   = prod_r;
    assign bus.busy      = s1_vld_r | s2_vld_r | s3_vld_r;

    // Partial-product rows; in signed mode the bits pairing exactly one sign bit are inverted.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp_s[i] = '0;
            for (int j = 0; j < WIDTH; j++) begin
                pp_s[i][i+j] = (s1_a_r[j] & s1_b_r[i]) ^
                               (s1_sgn_r & ((i == WIDTH - 32'sd1) != (j == WIDTH - 32'sd1)));
            end
        end
    end

    // Carry-save reduction: groups of four rows through 4:2 compressors, a leftover
    // triple through full adders, a leftover pair through half adders, until two rows remain.
    always_comb begin
        row_t cur [WIDTH];
        row_t nxt [WIDTH];
        row_t s1;
        row_t c1;
        int   n;
        int   q;
        int   r;
        int   m;
        cur = pp_s;
        n   = WIDTH;
        m   = WIDTH;
        for (int lvl = 0; lvl < WIDTH; lvl++) begin
            q = n / 32'sd4;
            r = n % 32'sd4;
            for (int k = 0; k < WIDTH; k++) begin
                nxt[k] = '0;
            end
            for (int g = 0; g < WIDTH / 32'sd4; g++) begin
                s1 = fa_sum(cur[4*g], cur[4*g+1], cur[4*g+2]);
                c1 = fa_carry(cur[4*g], cur[4*g+1], cur[4*g+2]);
                nxt[2*g]   = (g < q) ? fa_sum(s1, c1, cur[4*g+3])   : '0;
                nxt[2*g+1] = (g < q) ? fa_carry(s1, c1, cur[4*g+3]) : '0;
            end
            case (r)
                32'sd3: begin
                    nxt[2*q]   = fa_sum(cur[4*q], cur[4*q+1], cur[4*q+2]);
                    nxt[2*q+1] = fa_carry(cur[4*q], cur[4*q+1], cur[4*q+2]);
                    m          = 32'sd2 * q + 32'sd2;
                end
                32'sd2: begin
                    nxt[2*q]   = ha_sum(cur[4*q], cur[4*q+1]);
                    nxt[2*q+1] = ha_carry(cur[4*q], cur[4*q+1]);
                    m          = 32'sd2 * q + 32'sd2;
                end
                32'sd1: begin
                    nxt[2*q] = cur[4*q];
                    m        = 32'sd2 * q + 32'sd1;
                end
                default: begin
                    m = 32'sd2 * q;
                end
            endcase
            for (int k = 0; k < WIDTH; k++) begin
                cur[k] = (n > 32'sd2) ? nxt[k] : cur[k];
            end
            n = (n > 32'sd2) ? m : n;
        end
        red_sum_s   = cur[0];
        red_carry_s = cur[1];
    end

    // Pipeline registers: all stages advance together on en, reset discards everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_sgn_r   <= 1'b0;
            s1_vld_r   <= 1'b0;
            s2_sum_r   <= '0;
            s2_carry_r <= '0;
            s2_sgn_r   <= 1'b0;
            s2_vld_r   <= 1'b0;
            prod_r     <= '0;
            s3_vld_r   <= 1'b0;
        end else if (en_s) begin
            s1_a_r     <= bus.A;
            s1_b_r     <= bus.B;
            s1_sgn_r   <= bus.in_signed;
            s1_vld_r   <= bus.in_valid;
            s2_sum_r   <= red_sum_s;
            s2_carry_r <= red_carry_s;
            s2_sgn_r   <= s1_sgn_r;
            s2_vld_r   <= s1_vld_r;
            prod_r     <= s2_sum_r + s2_carry_r + (s2_sgn_r ? BW_CONST : row_t'(1'b0));
            s3_vld_r   <= s2_vld_r;
        end
    end
endmodule
